// File: rtl/dac_pkg.sv
// Shared types and defaults for the DAC sample feed path.
//   sample_t          : 16-bit signed audio sample
//   SAMPLE_PERIOD_DEF : clk cycles per audio sample (100 MHz / 48 kHz, truncated)
//   RAMP_SHIFT_DEF    : interpolation ramp length is 2^RAMP_SHIFT cycles
//   interp_state_t    : interpolator playback state (MUTE / PLAY)
package dac_pkg;

  localparam int SAMPLE_W          = 16;
  localparam int SAMPLE_PERIOD_DEF = 2083;
  localparam int RAMP_SHIFT_DEF    = 11;

  typedef logic signed [SAMPLE_W-1:0] sample_t;

  typedef enum logic {
    MUTE = 1'b0,
    PLAY = 1'b1
  } interp_state_t;

endpackage

// File: rtl/sample_fifo.sv
// Small synchronous FIFO with first-word-fall-through read data.
// Ports:
//   clk, rst   : clock and synchronous active-low reset (clears pointers/count)
//   i_push     : write i_din when not full
//   i_din      : write data
//   i_pop      : advance read pointer when not empty
//   o_dout     : head entry (valid whenever o_empty is low)
//   o_full     : DEPTH entries held
//   o_empty    : no entries held
//   o_level    : current occupancy, 0..DEPTH
module sample_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 16,
  localparam int AW = $clog2(DEPTH),
  localparam int LW = AW + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_din,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_dout,
  output logic             o_full,
  output logic             o_empty,
  output logic [LW-1:0]    o_level
);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [LW-1:0]    r_count;
  logic             w_do_push;
  logic             w_do_pop;

  assign o_full    = (r_count == LW'(DEPTH));
  assign o_empty   = (r_count == '0);
  assign o_level   = r_count;
  assign o_dout    = r_mem[r_rd_ptr];
  assign w_do_push = i_push && !o_full;
  assign w_do_pop  = i_pop && !o_empty;

  // DEPTH is a power of two, so the pointers wrap naturally.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + LW'(1);
        2'b01:   r_count <= r_count - LW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Storage carries data only; no reset needed.
  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_wr_ptr] <= i_din;
  end

endmodule

// File: rtl/dac_sample_interp.sv
// Audio-rate to system-clock sample feeder for the delta-sigma DAC.
// Buffers incoming samples in a FIFO and emits a per-clock linear
// interpolation between consecutive samples, with prefill, underrun
// soft-mute and recovery.
// Ports:
//   clk            : system clock
//   rst            : synchronous active-low reset
//   sample_in      : signed audio sample, accepted when sample_valid && sample_ready
//   sample_valid   : sample_in valid
//   sample_ready   : FIFO not full
//   current_sample : registered interpolated output to the DAC
//   underrun       : one-cycle pulse when a PLAY tick finds the FIFO empty
//   fifo_level     : FIFO occupancy
module dac_sample_interp
  import dac_pkg::*;
#(
  parameter int SAMPLE_PERIOD = SAMPLE_PERIOD_DEF,
  parameter int RAMP_SHIFT    = RAMP_SHIFT_DEF,
  parameter int FIFO_DEPTH    = 4,
  parameter int PREFILL       = 2,
  localparam int LW = $clog2(FIFO_DEPTH) + 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic signed [15:0]   sample_in,
  input  logic                 sample_valid,
  output logic                 sample_ready,
  output logic signed [15:0]   current_sample,
  output logic                 underrun,
  output logic [LW-1:0]        fifo_level
);

  localparam int CW = $clog2(SAMPLE_PERIOD);
  localparam int PW = 17 + RAMP_SHIFT + 2;
  localparam logic [RAMP_SHIFT:0] RAMP_FULL = {1'b1, {RAMP_SHIFT{1'b0}}};

  // prev + floor((target - prev) * ramp / 2^RAMP_SHIFT). The arithmetic
  // right shift of the signed product rounds toward -inf, and the result
  // always lies between prev and target, so the 16-bit slice cannot wrap.
  function automatic sample_t interp_point(input sample_t prev,
                                           input sample_t tgt,
                                           input logic [RAMP_SHIFT:0] ramp);
    logic signed [16:0]           delta;
    logic signed [RAMP_SHIFT+1:0] ramp_s;
    logic signed [PW-1:0]         prod;
    logic signed [PW-1:0]         step;
    logic signed [16:0]           sum;
    delta  = {tgt[15], tgt} - {prev[15], prev};
    ramp_s = {1'b0, ramp};
    prod   = PW'(delta) * PW'(ramp_s);
    step   = prod >>> RAMP_SHIFT;
    sum    = {prev[15], prev} + step[16:0];
    return sum[15:0];
  endfunction

  interp_state_t       r_state;
  interp_state_t       w_state_nxt;
  logic [CW-1:0]       r_cnt;
  logic [RAMP_SHIFT:0] r_ramp;
  sample_t             r_prev;
  sample_t             r_target;
  sample_t             r_cur;
  logic                r_underrun;

  logic                w_tick;
  logic                w_push;
  logic                w_pop;
  logic                w_full;
  logic                w_empty;
  logic [LW-1:0]       w_level;
  logic [15:0]         w_head;
  sample_t             w_target_nxt;
  sample_t             w_interp;
  logic                w_underrun;

  assign w_tick         = (r_cnt == CW'(SAMPLE_PERIOD - 1));
  assign w_push         = sample_valid && sample_ready;
  assign w_interp       = interp_point(r_prev, r_target, r_ramp);
  assign sample_ready   = !w_full;
  assign current_sample = r_cur;
  assign underrun       = r_underrun;
  assign fifo_level     = w_level;

  sample_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (16)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_push  (w_push),
    .i_din   (sample_in),
    .i_pop   (w_pop),
    .o_dout  (w_head),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_level (w_level)
  );

  // Decisions use the registered FIFO count, so a push landing on the
  // tick cycle is only seen by the following tick.
  always_comb begin
    w_state_nxt  = r_state;
    w_pop        = 1'b0;
    w_target_nxt = '0;
    w_underrun   = 1'b0;
    case (r_state)
      MUTE: begin
        if (w_tick && (w_level >= LW'(PREFILL))) begin
          w_pop        = 1'b1;
          w_target_nxt = w_head;
          w_state_nxt  = PLAY;
        end
      end
      PLAY: begin
        if (w_tick) begin
          if (!w_empty) begin
            w_pop        = 1'b1;
            w_target_nxt = w_head;
          end else begin
            w_underrun  = 1'b1;
            w_state_nxt = MUTE;
          end
        end
      end
      default: w_state_nxt = MUTE;
    endcase
  end

  // Ramp restarts from the value being output at the tick, so a ramp cut
  // short by a new target continues without a jump.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state    <= MUTE;
      r_cnt      <= '0;
      r_prev     <= '0;
      r_target   <= '0;
      r_ramp     <= RAMP_FULL;
      r_cur      <= '0;
      r_underrun <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_underrun <= w_underrun;
      r_cur      <= w_interp;
      r_cnt      <= w_tick ? '0 : r_cnt + CW'(1);
      if (w_tick) begin
        r_prev   <= w_interp;
        r_target <= w_target_nxt;
        r_ramp   <= '0;
      end else if (r_ramp != RAMP_FULL) begin
        r_ramp   <= r_ramp + (RAMP_SHIFT+1)'(1);
      end
    end
  end

endmodule

// File: tb/tb_dac_sample_interp.sv
module tb_dac_sample_interp;

  localparam int P     = 2083;
  localparam int RF    = 2048;
  localparam int DEPTH = 4;

  logic               clk = 1'b0;
  logic               rst;
  logic signed [15:0] sample_in;
  logic               sample_valid;
  logic               sample_ready;
  logic signed [15:0] current_sample;
  logic               underrun;
  logic [2:0]         fifo_level;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;

  // Reference model state
  bit m_en = 0;
  bit m_log = 0;
  int m_q[$];
  int m_acc[$];
  int m_cnt = 0;
  bit m_play = 0;
  int m_prev = 0, m_tgt = 0, m_ramp = RF, m_cur = 0;
  bit m_und = 0;
  int m_tick_cyc = -1;
  int m_lvl, m_interp, m_nt;
  bit m_tk;

  int rnd_mode = 0;

  typedef struct {
    bit          push;
    logic [15:0] val;
    bit          wtick;
    int          off;
    int          exp;
  } vec_t;
  vec_t tbl[12];

  dac_sample_interp #(
    .SAMPLE_PERIOD (P),
    .RAMP_SHIFT    (11),
    .FIFO_DEPTH    (DEPTH),
    .PREFILL       (2)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .sample_in      (sample_in),
    .sample_valid   (sample_valid),
    .sample_ready   (sample_ready),
    .current_sample (current_sample),
    .underrun       (underrun),
    .fifo_level     (fifo_level)
  );

  always #5 clk = ~clk;

  function automatic int fdiv(input int a);
    if (a >= 0) return a / RF;
    return -((-a + RF - 1) / RF);
  endfunction

  task automatic chk(input string nm, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Behavioural model: FIFO as a queue, ramp as integer floor division.
  always @(posedge clk) begin
    cyc++;
    if (!rst) begin
      m_q.delete();
      m_cnt = 0; m_play = 0; m_prev = 0; m_tgt = 0; m_ramp = RF; m_cur = 0; m_und = 0;
    end else begin
      m_lvl    = m_q.size();
      m_tk     = (m_cnt == P - 1);
      m_interp = m_prev + fdiv((m_tgt - m_prev) * m_ramp);
      m_cur    = m_interp;
      m_und    = 0;
      if (m_tk) begin
        m_tick_cyc = cyc;
        m_nt = 0;
        if (!m_play) begin
          if (m_lvl >= 2) begin m_nt = m_q.pop_front(); m_play = 1; end
        end else if (m_lvl > 0) begin
          m_nt = m_q.pop_front();
        end else begin
          m_und = 1; m_play = 0;
        end
        m_prev = m_interp; m_tgt = m_nt; m_ramp = 0;
      end else if (m_ramp < RF) begin
        m_ramp++;
      end
      if (sample_valid && m_lvl < DEPTH) begin
        m_q.push_back(int'(sample_in));
        if (m_log) m_acc.push_back(int'(sample_in));
      end
      m_cnt = m_tk ? 0 : m_cnt + 1;
    end
  end

  always @(negedge clk) begin
    if (m_en) begin
      chk("model_cur", int'(current_sample), m_cur);
      chk("model_und", int'(underrun), int'(m_und));
      chk("model_lvl", int'(fifo_level), m_q.size());
      chk("model_rdy", int'(sample_ready), int'(m_q.size() < DEPTH));
    end
  end

  task automatic cyc1();
    @(posedge clk);
    #1;
    if (rnd_mode == 1) begin
      sample_valid = 1'b1;
      sample_in    = 16'($urandom);
    end else if (rnd_mode == 2) begin
      sample_valid = ($urandom_range(0, 2499) == 0);
      sample_in    = 16'($urandom);
    end
  endtask

  task automatic step(input int n);
    repeat (n) cyc1();
  endtask

  task automatic wait_tick();
    bit got = 0;
    for (int i = 0; i < P + 4 && !got; i++) begin
      cyc1();
      if (m_tick_cyc == cyc) got = 1;
    end
    chk("tick_seen", int'(got), 1);
  endtask

  task automatic push(input logic [15:0] v);
    sample_in    = v;
    sample_valid = 1'b1;
    cyc1();
    sample_valid = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    step(2);
    rst = 1'b1;
  endtask

  initial begin
    int viol;
    int last;
    int cur_off;
    rst = 1'b0; sample_in = '0; sample_valid = 1'b0;

    tbl[0]  = '{1'b0, 16'h0000, 1'b1, 0,    0};
    tbl[1]  = '{1'b0, 16'h0000, 1'b0, 1,    0};
    tbl[2]  = '{1'b0, 16'h0000, 1'b0, 2,    8};
    tbl[3]  = '{1'b0, 16'h0000, 1'b0, 1025, 8192};
    tbl[4]  = '{1'b0, 16'h0000, 1'b0, 2048, 16376};
    tbl[5]  = '{1'b0, 16'h0000, 1'b0, 2049, 16384};
    tbl[6]  = '{1'b0, 16'h0000, 1'b1, 5,    16384};
    tbl[7]  = '{1'b1, 16'hC000, 1'b1, 2,    16368};
    tbl[8]  = '{1'b0, 16'h0000, 1'b0, 1025, 0};
    tbl[9]  = '{1'b0, 16'h0000, 1'b0, 2049, -16384};
    tbl[10] = '{1'b1, 16'h7FFF, 1'b1, 2049, 32767};
    tbl[11] = '{1'b1, 16'h8000, 1'b1, 2,    32735};

    // Reset state and idle behaviour
    step(2);
    m_en = 1;
    chk("rst_cur", int'(current_sample), 0);
    chk("rst_rdy", int'(sample_ready), 1);
    chk("rst_lvl", int'(fifo_level), 0);
    chk("rst_und", int'(underrun), 0);
    rst = 1'b1;
    viol = 0;
    repeat (3 * P) begin
      cyc1();
      if (current_sample !== 16'sd0 || underrun !== 1'b0 ||
          sample_ready !== 1'b1 || fifo_level !== 3'd0) viol++;
    end
    chk("idle_viol", viol, 0);

    // Prefill, ramps and large steps
    do_reset();
    push(16'h4000);
    push(16'h4000);
    cur_off = 0;
    for (int i = 0; i < 12; i++) begin
      if (tbl[i].push) push(tbl[i].val);
      if (tbl[i].wtick) begin wait_tick(); cur_off = 0; end
      step(tbl[i].off - cur_off);
      cur_off = tbl[i].off;
      chk($sformatf("vec%0d", i), int'(current_sample), tbl[i].exp);
    end

    // Full-scale fall from 0x7FFF to 0x8000 must never rise or wrap
    last = int'(current_sample);
    viol = 0;
    for (int k = 3; k <= 2049; k++) begin
      cyc1();
      if (int'(current_sample) > last) viol++;
      last = int'(current_sample);
    end
    chk("mono_viol", viol, 0);
    chk("mono_final", int'(current_sample), -32768);

    // Continuous valid: FIFO saturates, order preserved
    m_acc.delete();
    m_log = 1;
    rnd_mode = 1;
    step(6);
    chk("sat_lvl", int'(fifo_level), 4);
    chk("sat_rdy", int'(sample_ready), 0);
    for (int k = 0; k < 4; k++) begin
      wait_tick();
      chk("sat_tick_lvl", int'(fifo_level), 3);
      step(1);
      chk("sat_refill_lvl", int'(fifo_level), 4);
      chk("sat_refill_rdy", int'(sample_ready), 0);
      step(2048);
      chk($sformatf("order%0d", k), int'(current_sample), m_acc[k]);
    end

    // Sparse random traffic with underruns
    m_log = 0;
    rnd_mode = 2;
    step(6 * P);
    rnd_mode = 0;
    sample_valid = 1'b0;

    // Starvation, soft mute, MUTE re-entry, reset mid-ramp
    do_reset();
    push(16'h4000);
    push(16'h4000);
    wait_tick();
    wait_tick();
    step(2049);
    chk("starve_settled", int'(current_sample), 16384);
    chk("starve_lvl", int'(fifo_level), 0);
    wait_tick();
    chk("und_pulse", int'(underrun), 1);
    step(1);
    chk("und_clear", int'(underrun), 0);
    step(1024);
    chk("mute_half", int'(current_sample), 8192);
    step(1024);
    chk("mute_zero", int'(current_sample), 0);
    push(16'h1234);
    wait_tick();
    chk("mute_no_und", int'(underrun), 0);
    step(2049);
    chk("mute_hold_cur", int'(current_sample), 0);
    chk("mute_hold_lvl", int'(fifo_level), 1);
    push(16'h1234);
    wait_tick();
    chk("replay_lvl", int'(fifo_level), 1);
    step(1000);
    chk("replay_mid", int'(current_sample), fdiv(4660 * 999));
    rst = 1'b0;
    step(1);
    chk("midrst_cur", int'(current_sample), 0);
    chk("midrst_lvl", int'(fifo_level), 0);
    chk("midrst_rdy", int'(sample_ready), 1);
    chk("midrst_und", int'(underrun), 0);
    rst = 1'b1;
    step(3);
    chk("post_rst_cur", int'(current_sample), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/dac_sample_interp.md
Name: dac_sample_interp

Overview:
- Upstream feeder for the delta-sigma DAC stage. It accepts 16-bit signed audio samples at the audio rate (about 48 kHz) through a valid/ready handshake and buffers them in a small FIFO.
- It drives a per-clock, linearly interpolated 16-bit signed `current_sample` into the DAC at the 100 MHz system clock.
- This removes the zero-order-hold staircase images the modulator would otherwise pass through.
- It handles prefill, underrun soft-mute and recovery.

Parameters:
- SAMPLE_PERIOD, 2083, clk cycles per output audio sample (100 MHz / 48 kHz, truncated).
- RAMP_SHIFT, 11, ramp length is 2^RAMP_SHIFT cycles; must satisfy 2^RAMP_SHIFT <= SAMPLE_PERIOD.
- FIFO_DEPTH, 4, input buffer entries (power of two, >= 2).
- PREFILL, 2, FIFO occupancy required to leave MUTE.

Ports:
- clk, input, 1, system clock (100 MHz).
- rst, input, 1, reset: synchronous, active-low (asserted when 0).
- sample_in, input, 16, signed audio sample.
- sample_valid, input, 1, sample_in is valid this cycle.
- sample_ready, output, 1, FIFO can accept; transfer occurs when valid && ready.
- current_sample, output, 16, signed interpolated sample to the DAC, registered.
- underrun, output, 1, one-cycle pulse when a tick finds the FIFO empty while in PLAY.
- fifo_level, output, $clog2(FIFO_DEPTH)+1, current FIFO occupancy.

Behaviour:
- Reset (rst==0 at posedge): FIFO empty; period counter 0; state MUTE; prev = target = 0; ramp_cnt = 2^RAMP_SHIFT (settled); current_sample = 0; underrun = 0; sample_ready = 1 from the first cycle after reset. Reset mid-ramp discards all buffered data.
- Period counter: counts 0..SAMPLE_PERIOD-1, then wraps. It runs freely in every state. `tick` is asserted when the counter equals SAMPLE_PERIOD-1, so the first tick occurs SAMPLE_PERIOD-1 cycles after reset release.
- FIFO:
  - sample_ready = !full, based on the registered count.
  - A push while full is impossible because ready is low.
  - A simultaneous push and pop (not full, not empty) leaves the count unchanged and preserves data order.
  - Pops happen only on tick.
- Interpolation (applies in all states):
  - delta = target - prev, computed as a 17-bit signed value.
  - Each cycle, ramp_cnt increments and saturates at 2^RAMP_SHIFT.
  - current_sample (next) = prev + floor(delta * ramp_cnt / 2^RAMP_SHIFT), using an arithmetic shift that rounds toward -inf.
  - The result always lies between prev and target, so no clamp is needed.
  - Implementation may use a multiplier or an accumulator, but must be bit-exact to this formula.
  - Output register latency is 1 cycle.
- On every tick that loads a new target:
  - prev <= current interpolated value (not the old target), so a ramp interrupted by a tick stays continuous.
  - target <= new value.
  - ramp_cnt <= 0.
- State machine:
  - MUTE:
    - On tick with fifo_level >= PREFILL: pop the head into target; go to PLAY.
    - Otherwise: target <= 0.
  - PLAY:
    - On tick with FIFO non-empty: pop into target.
    - On tick with FIFO empty: pulse underrun; target <= 0 (soft ramp to silence); go to MUTE.
  - A push arriving in the same cycle as a tick is not visible to that tick's empty/PREFILL check; it uses the registered count.
- Width rules:
  - All arithmetic is signed.
  - delta spans -65535..65535 and needs 17 bits.
  - The product needs 17 + RAMP_SHIFT + 1 bits.

Decomposition:
- Package dac_pkg: `sample_t` (logic signed [15:0]), the SAMPLE_PERIOD and RAMP_SHIFT defaults shared with the DAC top, and the state enum `interp_state_t` {MUTE, PLAY}.
- One sub-module: `sample_fifo`, a synchronous FIFO with push/pop/full/empty/level, parameterised by depth and width, using the same active-low synchronous rst.
- The interpolator datapath and FSM stay in dac_sample_interp.

Test Plan:
1. Reset, then no input -> current_sample = 0 and underrun = 0 for 3*SAMPLE_PERIOD cycles; sample_ready = 1; fifo_level = 0.
2. Push 0x4000, 0x4000 before the first tick:
   - At tick: state PLAY, ramp from 0 begins.
   - 1025 cycles after the tick, current_sample = 0x2000.
   - From 2049 cycles after the tick until the next tick, current_sample = 0x4000.
3. Settled at 0x4000 (+16384), next sample 0xC000 (-16384):
   - delta = -32768.
   - Two cycles after the tick, current_sample = 16384 - 16 = 16368 (0x3FF0).
   - The output ends at 0xC000.
4. Extreme step from 0x7FFF to 0x8000 -> monotonic decrease with no wrap; the final value is exactly 0x8000.
5. Hold sample_valid high constantly -> fifo_level saturates at 4 and sample_ready drops. Check:
   - A concurrent push at a tick keeps the level at 4 only if ready was high.
   - Output order matches input order.
6. Starve the FIFO during PLAY at settled 0x4000:
   - At the next tick, underrun pulses for exactly 1 cycle.
   - The output ramps to 0 over 2048 cycles and the state returns to MUTE.
   - Pulling rst low mid-ramp forces current_sample = 0 on the next cycle.
